pixel_unpacker: RTL and testbench
=================================

Name: pixel_unpacker

Overview:
- Receive-side stage directly upstream of the display data controller's pixel FIFO.
- Consumes the stripped UDP payload byte stream: a 2-byte line header followed by 4:2:2 Y/C byte pairs.
- Packs each Y/C pair with the header's block and line indices into the 29-bit FIFO word {x_count[1:0], y_count[10:0], Y[7:0], C[7:0]} that the controller reads.
- Enforces packet framing and drops bad packets; it never stalls the byte stream.

Parameters:
- PIXELS_PER_PKT, 600, pixels per packet (one horizontal half-line block).
- V_LINES, 720, line indices at or above this value are rejected.
- CNT_W, 16, width of the statistics counters.

Ports:
- i_clk_125M  input  1  receive byte clock; all logic is on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  byte strobe; one byte per cycle when high.
- i_data  input  8  payload byte.
- i_sop  input  1  first byte of payload; qualified by i_valid.
- i_eop  input  1  last byte of payload; qualified by i_valid.
- i_fifo_full  input  1  pixel FIFO full flag (write side).
- o_wr_en  output  1  FIFO write strobe, one cycle per pixel.
- o_wr_data  output  29  {x_count, y_count, Y, C}.
- o_busy  output  1  high while not in IDLE.
- o_pkt_cnt  output  CNT_W  complete packets written.
- o_drop_cnt  output  CNT_W  packets dropped or malformed.

Behaviour:
- Reset values: o_wr_en=0, o_wr_data=0, o_pkt_cnt=0, o_drop_cnt=0, state=IDLE, pixel counter=0.
- Reset is asynchronous. Asserting it mid-packet returns to IDLE immediately.
- After reset, bytes without i_sop are ignored until the next i_sop.
- Cycles with i_valid low change no state.
- Header format, big-endian 16 bits: [15:14]=x_count, [13:11]=reserved (ignored), [10:0]=y_count.
- FSM states: IDLE, HDR_LO, PIX_Y, PIX_C, DROP.
- IDLE:
  - On i_valid&i_sop, latch the byte as the header high byte and go to HDR_LO.
  - If i_eop is also set on that byte, count a drop and stay in IDLE.
- HDR_LO:
  - Latch the low byte and clear the pixel counter.
  - If y_count >= V_LINES, go to DROP; otherwise go to PIX_Y.
  - i_eop here: count a drop, go to IDLE.
- PIX_Y: latch the Y byte and go to PIX_C. i_eop here: count a drop, go to IDLE.
- PIX_C:
  - If i_fifo_full is high, write nothing, go to DROP, and count a drop once.
  - Otherwise register o_wr_en=1 and o_wr_data={x,y,Y,i_data}.
  - Latency: o_wr_en is high exactly the cycle after the C byte is accepted, for one cycle.
  - If the pixel counter equals PIXELS_PER_PKT-1 and i_eop is set: o_pkt_cnt++ and go to IDLE.
  - If the pixel counter equals PIXELS_PER_PKT-1 and i_eop is clear: count a drop and go to DROP (overlong packet). The last pixel is still written.
  - If the counter is below PIXELS_PER_PKT-1 and i_eop is set: count a drop and go to IDLE (short packet; pixels already written stand).
  - Otherwise increment the counter and go to PIX_Y.
- DROP: discard bytes until i_valid&i_eop, then go to IDLE. A drop is counted once per packet, never per byte.
- i_sop seen in any state other than IDLE:
  - Abort the current packet and count a drop.
  - Treat the byte as a new header high byte and go to HDR_LO.
  - If the abort happens in PIX_C, no write is made for that byte.
- Counters saturate at all-ones and do not wrap.
- A full FIFO on a PIX_C cycle takes priority over i_eop and i_sop on that byte: the drop is counted once, then the i_eop / i_sop handling above applies.

Decomposition:
- Shared package holds:
  - the FIFO word layout constants: PIX_W=29, XC_MSB=28, XC_LSB=27, YC_MSB=26, YC_LSB=16, Y_MSB=15, C_MSB=7;
  - the FSM state encoding;
  - the header field positions.
- The controller-side FIFO word unpacking uses the same package.
- One sub-module, sat_counter (parameter CNT_W, inputs inc and clear), is instantiated twice for o_pkt_cnt and o_drop_cnt.

Test Plan:
- Good packet: sop, header 0x82CF (x=2, y=0x2CF=719), 600 Y/C pairs with Y=i[7:0] and C=~i[7:0], eop on the last C.
  - Expect 600 writes; first o_wr_data={2'd2, 11'd719, 8'h00, 8'hFF}.
  - Each write appears the cycle after its C byte; o_pkt_cnt=1, o_drop_cnt=0.
- Header y=720: expect no writes, o_drop_cnt=1. The following good packet is written normally.
- i_fifo_full raised at pixel 100 for one cycle:
  - pixels 0..99 written, no further writes for that packet, o_drop_cnt=1, state IDLE after eop.
  - Next packet: o_pkt_cnt increments.
- Short packet with eop after 10 pixels: expect 10 writes, o_drop_cnt=1, o_pkt_cnt unchanged. Overlong packet (601 pairs): 600 writes, o_drop_cnt=1.
- New sop at pixel 50 of a packet: expect 50 writes from packet one, o_drop_cnt=1, then the new packet is written in full and o_pkt_cnt=1.
- i_rst_n pulsed low mid-packet:
  - outputs go to zero asynchronously;
  - remaining bytes without sop produce no writes;
  - the next sop packet is processed normally.
- Force o_drop_cnt to 0xFFFF, then drop again: it holds 0xFFFF.

Source files
------------

// File: rtl/pixel_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// pixel_unpacker_pkg
//
// Definitions shared by the receive-side pixel unpacker and by the display
// controller that reads the pixel FIFO on the other side.
//
//   * FIFO word layout (29 bits): {x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}
//   * Line header layout (16 bits, big-endian on the wire):
//       [15:14] x_count, [13:11] reserved, [10:0] y_count
//   * Unpacker FSM state encoding
//   * pack / unpack helpers so both ends of the FIFO agree on bit positions
// -----------------------------------------------------------------------------
package pixel_unpacker_pkg;

    // FIFO word layout
    localparam int PIX_W  = 29;
    localparam int XC_MSB = 28;
    localparam int XC_LSB = 27;
    localparam int YC_MSB = 26;
    localparam int YC_LSB = 16;
    localparam int Y_MSB  = 15;
    localparam int Y_LSB  = 8;
    localparam int C_MSB  = 7;
    localparam int C_LSB  = 0;

    // Line header field positions within the 16-bit header
    localparam int HDR_XC_MSB = 15;
    localparam int HDR_XC_LSB = 14;
    localparam int HDR_YC_MSB = 10;
    localparam int HDR_YC_LSB = 0;

    // The same fields as seen inside the first (high) header byte
    localparam int HDR_HI_XC_MSB = HDR_XC_MSB - 8;
    localparam int HDR_HI_XC_LSB = HDR_XC_LSB - 8;
    localparam int HDR_HI_YC_MSB = HDR_YC_MSB - 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_PIX_Y  = 3'd2,
        ST_PIX_C  = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]  x_count;
        logic [10:0] y_count;
        logic [7:0]  luma;
        logic [7:0]  chroma;
    } pix_word_t;

    // Builds a FIFO word from its fields.
    function automatic logic [PIX_W-1:0] pack_pix(
        input logic [1:0]  x_count,
        input logic [10:0] y_count,
        input logic [7:0]  luma,
        input logic [7:0]  chroma
    );
        logic [PIX_W-1:0] w;
        w                = '0;
        w[XC_MSB:XC_LSB] = x_count;
        w[YC_MSB:YC_LSB] = y_count;
        w[Y_MSB:Y_LSB]   = luma;
        w[C_MSB:C_LSB]   = chroma;
        return w;
    endfunction

    // Splits a FIFO word back into its fields (controller read side).
    function automatic pix_word_t unpack_pix(input logic [PIX_W-1:0] w);
        pix_word_t p;
        p.x_count = w[XC_MSB:XC_LSB];
        p.y_count = w[YC_MSB:YC_LSB];
        p.luma    = w[Y_MSB:Y_LSB];
        p.chroma  = w[C_MSB:C_LSB];
        return p;
    endfunction

endpackage

// File: rtl/pixel_unpacker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Statistics counter that increments by one per cycle on 'inc' and sticks at
// all-ones instead of wrapping, so a long-running link never reports a
// misleadingly small count.
//
// Ports:
//   i_clk_125M  in   clock, rising edge
//   i_rst_n     in   asynchronous active-low reset (count -> 0)
//   inc         in   increment request for this cycle
//   clear       in   synchronous clear, wins over inc
//   count       out  CNT_W-bit counter value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk_125M,
    input  logic             i_rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_clk_125M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// -----------------------------------------------------------------------------
// pixel_unpacker
//
// Receive-side stage in front of the display controller's pixel FIFO. Takes
// the stripped UDP payload (2-byte line header, then 4:2:2 Y/C byte pairs) and
// writes one 29-bit FIFO word per Y/C pair:
//     {x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}
// Malformed packets (bad line index, wrong length, FIFO overflow, restart via a
// new SOP) are dropped and counted. The byte stream is never back-pressured.
//
// Ports:
//   i_clk_125M   in   receive byte clock
//   i_rst_n      in   asynchronous active-low reset
//   i_valid      in   byte strobe
//   i_data[7:0]  in   payload byte
//   i_sop        in   first payload byte (qualified by i_valid)
//   i_eop        in   last payload byte (qualified by i_valid)
//   i_fifo_full  in   pixel FIFO full flag
//   o_wr_en      out  FIFO write strobe, one cycle per pixel
//   o_wr_data    out  FIFO word
//   o_busy       out  high while a packet is being parsed or discarded
//   o_pkt_cnt    out  complete packets written (saturating)
//   o_drop_cnt   out  packets dropped or malformed (saturating)
// -----------------------------------------------------------------------------
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int PIXELS_PER_PKT = 600,
    parameter int V_LINES        = 720,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk_125M,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic             i_fifo_full,
    output logic             o_wr_en,
    output logic [PIX_W-1:0] o_wr_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int PC_W = (PIXELS_PER_PKT > 1) ? $clog2(PIXELS_PER_PKT) : 1;
    localparam logic [PC_W-1:0] PIX_LAST  = PC_W'(PIXELS_PER_PKT - 1);
    localparam logic [10:0]     V_LINES_L = 11'(V_LINES);

    state_t      state;
    logic [1:0]  hdr_x;      // x_count taken from the header high byte
    logic [2:0]  hdr_yhi;    // y_count[10:8] taken from the header high byte
    logic [1:0]  x_q;
    logic [10:0] y_q;
    logic [7:0]  y_byte;
    logic [PC_W-1:0] pix_cnt;
    logic        pkt_inc;
    logic        drop_inc;
    logic [10:0] hdr_y;

    // Full line index as it becomes known on the header low byte.
    assign hdr_y  = {hdr_yhi, i_data};
    assign o_busy = (state != ST_IDLE);

    // Counter events are registered pulses, so the statistics outputs move
    // one cycle after the byte that caused them.
    always_ff @(posedge i_clk_125M or negedge i_rst_n) begin
        // NOTE: the data-path registers are reset along with the control state
        // because o_wr_data must read zero out of reset, and a stale header
        // must never leak into a packet that starts after a reset.
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            hdr_x     <= '0;
            hdr_yhi   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            y_byte    <= '0;
            pix_cnt   <= '0;
            o_wr_en   <= 1'b0;
            o_wr_data <= '0;
            pkt_inc   <= 1'b0;
            drop_inc  <= 1'b0;
        end else begin
            o_wr_en  <= 1'b0;
            pkt_inc  <= 1'b0;
            drop_inc <= 1'b0;

            if (i_valid) begin
                if (i_sop && (state != ST_IDLE)) begin
                    // Restart: abandon the current packet and treat this byte
                    // as a new header. A packet already in DROP was counted on
                    // entry, so it is not counted a second time. An abort in
                    // PIX_C never writes the byte.
                    if (state != ST_DROP) begin
                        drop_inc <= 1'b1;
                    end
                    hdr_x   <= i_data[HDR_HI_XC_MSB:HDR_HI_XC_LSB];
                    hdr_yhi <= i_data[HDR_HI_YC_MSB:0];
                    state   <= i_eop ? ST_IDLE : ST_HDR_LO;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            // Anything before an SOP is ignored.
                            if (i_sop) begin
                                hdr_x   <= i_data[HDR_HI_XC_MSB:HDR_HI_XC_LSB];
                                hdr_yhi <= i_data[HDR_HI_YC_MSB:0];
                                if (i_eop) begin
                                    drop_inc <= 1'b1;
                                end else begin
                                    state <= ST_HDR_LO;
                                end
                            end
                        end

                        ST_HDR_LO: begin
                            x_q     <= hdr_x;
                            y_q     <= hdr_y;
                            pix_cnt <= '0;
                            if (i_eop) begin
                                drop_inc <= 1'b1;
                                state    <= ST_IDLE;
                            end else if (hdr_y >= V_LINES_L) begin
                                drop_inc <= 1'b1;
                                state    <= ST_DROP;
                            end else begin
                                state <= ST_PIX_Y;
                            end
                        end

                        ST_PIX_Y: begin
                            if (i_eop) begin
                                drop_inc <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                y_byte <= i_data;
                                state  <= ST_PIX_C;
                            end
                        end

                        ST_PIX_C: begin
                            if (i_fifo_full) begin
                                // Overflow costs the whole rest of the packet;
                                // a trailing EOP on this byte still closes it.
                                drop_inc <= 1'b1;
                                state    <= i_eop ? ST_IDLE : ST_DROP;
                            end else begin
                                o_wr_en   <= 1'b1;
                                o_wr_data <= pack_pix(x_q, y_q, y_byte, i_data);
                                if (pix_cnt == PIX_LAST) begin
                                    if (i_eop) begin
                                        pkt_inc <= 1'b1;
                                        state   <= ST_IDLE;
                                    end else begin
                                        // Overlong: keep the last pixel, skip
                                        // the excess up to the EOP.
                                        drop_inc <= 1'b1;
                                        state    <= ST_DROP;
                                    end
                                end else if (i_eop) begin
                                    // Short packet: pixels already written stand.
                                    drop_inc <= 1'b1;
                                    state    <= ST_IDLE;
                                end else begin
                                    pix_cnt <= pix_cnt + 1'b1;
                                    state   <= ST_PIX_Y;
                                end
                            end
                        end

                        ST_DROP: begin
                            if (i_eop) begin
                                state <= ST_IDLE;
                            end
                        end

                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_pkt_cnt (
        .i_clk_125M (i_clk_125M),
        .i_rst_n    (i_rst_n),
        .inc        (pkt_inc),
        .clear      (1'b0),
        .count      (o_pkt_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .i_clk_125M (i_clk_125M),
        .i_rst_n    (i_rst_n),
        .inc        (drop_inc),
        .clear      (1'b0),
        .count      (o_drop_cnt)
    );

endmodule

// File: tb/tb_pixel_unpacker.sv
// -----------------------------------------------------------------------------
// tb_pixel_unpacker
//
// Drives payload packets described at packet level (header fields, pair count,
// FIFO-full position, EOP present) and predicts from those rules alone which
// pixels must reach the FIFO, on which cycle, and how the packet and drop
// counters move. A narrow-counter second instance shares the stimulus so
// saturation is reached in a few dozen drops.
// -----------------------------------------------------------------------------
module tb_pixel_unpacker;

    localparam int PPP     = 600;
    localparam int V_LINES = 720;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        full;

    logic        wr_en;
    logic [28:0] wr_data;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    logic        s_wr_en;
    logic [28:0] s_wr_data;
    logic        s_busy;
    logic [3:0]  s_pkt_cnt;
    logic [3:0]  s_drop_cnt;

    pixel_unpacker #(.PIXELS_PER_PKT(PPP), .V_LINES(V_LINES), .CNT_W(16)) dut (
        .i_clk_125M (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_data     (data),
        .i_sop      (sop),
        .i_eop      (eop),
        .i_fifo_full(full),
        .o_wr_en    (wr_en),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_pkt_cnt  (pkt_cnt),
        .o_drop_cnt (drop_cnt)
    );

    pixel_unpacker #(.PIXELS_PER_PKT(PPP), .V_LINES(V_LINES), .CNT_W(4)) dut_small (
        .i_clk_125M (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_data     (data),
        .i_sop      (sop),
        .i_eop      (eop),
        .i_fifo_full(full),
        .o_wr_en    (s_wr_en),
        .o_wr_data  (s_wr_data),
        .o_busy     (s_busy),
        .o_pkt_cnt  (s_pkt_cnt),
        .o_drop_cnt (s_drop_cnt)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [28:0] word;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_wr_seen = 0;
    int   exp_pkt  = 0;
    int   exp_drop = 0;

    // Write monitor: every FIFO write must match the oldest predicted pixel,
    // on exactly the cycle after its C byte; a prediction whose cycle has
    // passed without a write is a missing pixel.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL missing_write: got no write, required data=%h at cycle %0d", e.word, e.at);
        end
        if (rst_n && wr_en) begin
            n_wr_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_write: got data=%h at cycle %0d, required no write", wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (wr_data !== e.word || cyc !== e.at) begin
                    n_fails++;
                    $display("FAIL write: got data=%h cycle=%0d, required data=%h cycle=%0d",
                             wr_data, cyc, e.word, e.at);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Idle cycles: strobe low, every other input random and must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid = 1'b0;
            data  = 8'($urandom);
            sop   = 1'($urandom);
            eop   = 1'($urandom);
            full  = 1'($urandom);
        end
    endtask

    // One accepted byte, occasionally preceded by an idle cycle. 'at' is the
    // cycle on which a write caused by this byte must be visible.
    task automatic drive_byte(input logic [7:0] d, input bit s, input bit e,
                              input bit f, output int at);
        if ($urandom_range(0, 7) == 0) idle(1);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        sop   = s;
        eop   = e;
        full  = f;
        at    = cyc + 1;
    endtask

    // Packet-level model: a packet is written up to 600 pixels if its line
    // index is legal, truncated at a FIFO-full pixel; it counts as complete
    // only with exactly 600 pairs, no overflow and a closing EOP.
    task automatic send_pkt(input logic [1:0] x, input logic [10:0] y, input int npairs,
                            input int full_at, input bit do_eop, input bit rand_data);
        logic [7:0] yb, cb;
        int         at, n_wr;
        bit         good_hdr;
        good_hdr = (int'(y) < V_LINES);
        n_wr     = good_hdr ? ((npairs < PPP) ? npairs : PPP) : 0;
        if (good_hdr && full_at >= 0 && full_at < n_wr) n_wr = full_at;
        drive_byte({x, 3'($urandom), y[10:8]}, 1'b1, 1'b0, 1'b0, at);
        drive_byte(y[7:0], 1'b0, (npairs == 0) && do_eop, 1'b0, at);
        for (int i = 0; i < npairs; i++) begin
            yb = rand_data ? 8'($urandom) : i[7:0];
            cb = rand_data ? 8'($urandom) : ~i[7:0];
            drive_byte(yb, 1'b0, 1'b0, 1'b0, at);
            drive_byte(cb, 1'b0, do_eop && (i == npairs - 1), i == full_at, at);
            if (i < n_wr) exp_q.push_back('{{x, y, yb, cb}, at});
        end
        if (good_hdr && npairs == PPP && full_at < 0 && do_eop) exp_pkt++;
        else exp_drop++;
    endtask

    task automatic test_reset();
        int at;
        rst_n = 1'b0;
        valid = 1'b0; data = '0; sop = 1'b0; eop = 1'b0; full = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wr_en, wr_data, pkt_cnt, drop_cnt, busy} !== '0) begin
            n_fails++;
            $display("FAIL reset_values: got en=%b data=%h pkt=%0d drop=%0d busy=%b, required all zero",
                     wr_en, wr_data, pkt_cnt, drop_cnt, busy);
        end
        rst_n = 1'b1;
        // Bytes without an SOP after reset are ignored.
        for (int i = 0; i < 20; i++) drive_byte(8'($urandom), 1'b0, 1'($urandom), 1'b0, at);
        idle(3);
        n_checks++;
        if (busy !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fails++;
            $display("FAIL pre_sop_ignored: got busy=%b drop=%0d, required busy=0 drop=0", busy, drop_cnt);
        end
    endtask

    task automatic test_good_packet();
        int w0 = n_wr_seen;
        send_pkt(2'd2, 11'd719, PPP, -1, 1'b1, 1'b0);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 600 || pkt_cnt !== 16'd1 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL good_packet: got writes=%0d pkt=%0d drop=%0d busy=%b, required 600/1/0/0",
                     n_wr_seen - w0, pkt_cnt, drop_cnt, busy);
        end
    endtask

    task automatic test_bad_header();
        int w0 = n_wr_seen;
        send_pkt(2'($urandom), 11'd720, PPP, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen !== w0 || drop_cnt !== 16'(exp_drop) || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL bad_header_720: got writes=%0d drop=%0d busy=%b, required 0/%0d/0",
                     n_wr_seen - w0, drop_cnt, busy, exp_drop);
        end
        send_pkt(2'($urandom), 11'($urandom_range(V_LINES, 2047)), 20, -1, 1'b1, 1'b1);
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 600 || pkt_cnt !== 16'(exp_pkt) || drop_cnt !== 16'(exp_drop)) begin
            n_fails++;
            $display("FAIL bad_header_then_good: got writes=%0d pkt=%0d drop=%0d, required 600/%0d/%0d",
                     n_wr_seen - w0, pkt_cnt, drop_cnt, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_fifo_full();
        int w0 = n_wr_seen;
        int d0 = exp_drop;
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP, 100, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 100 || drop_cnt !== 16'(d0 + 1) || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL fifo_full: got writes=%0d drop=%0d busy=%b, required 100/%0d/0",
                     n_wr_seen - w0, drop_cnt, busy, d0 + 1);
        end
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (pkt_cnt !== 16'(exp_pkt) || drop_cnt !== 16'(d0 + 1)) begin
            n_fails++;
            $display("FAIL fifo_full_recover: got pkt=%0d drop=%0d, required %0d/%0d",
                     pkt_cnt, drop_cnt, exp_pkt, d0 + 1);
        end
    endtask

    task automatic test_short_long();
        int w0 = n_wr_seen;
        int p0 = exp_pkt;
        int d0 = exp_drop;
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), 10, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 10 || pkt_cnt !== 16'(p0) || drop_cnt !== 16'(d0 + 1)) begin
            n_fails++;
            $display("FAIL short_packet: got writes=%0d pkt=%0d drop=%0d, required 10/%0d/%0d",
                     n_wr_seen - w0, pkt_cnt, drop_cnt, p0, d0 + 1);
        end
        w0 = n_wr_seen;
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP + 1, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 600 || pkt_cnt !== 16'(p0) || drop_cnt !== 16'(d0 + 2) || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL overlong_packet: got writes=%0d pkt=%0d drop=%0d busy=%b, required 600/%0d/%0d/0",
                     n_wr_seen - w0, pkt_cnt, drop_cnt, busy, p0, d0 + 2);
        end
    endtask

    task automatic test_sop_abort();
        int w0 = n_wr_seen;
        int p0 = exp_pkt;
        int d0 = exp_drop;
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), 50, -1, 1'b0, 1'b1);
        idle(2);
        n_checks++;
        if (busy !== 1'b1 || n_wr_seen - w0 !== 50) begin
            n_fails++;
            $display("FAIL sop_abort_midway: got busy=%b writes=%0d, required busy=1 writes=50",
                     busy, n_wr_seen - w0);
        end
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 650 || pkt_cnt !== 16'(p0 + 1) || drop_cnt !== 16'(d0 + 1)) begin
            n_fails++;
            $display("FAIL sop_abort: got writes=%0d pkt=%0d drop=%0d, required 650/%0d/%0d",
                     n_wr_seen - w0, pkt_cnt, drop_cnt, p0 + 1, d0 + 1);
        end
    endtask

    task automatic test_saturation();
        int at;
        for (int i = 0; i < 20; i++) begin
            drive_byte(8'($urandom), 1'b1, 1'b1, 1'b0, at);
            exp_drop++;
        end
        idle(4);
        n_checks++;
        if (drop_cnt !== 16'(exp_drop) || s_drop_cnt !== 4'hF) begin
            n_fails++;
            $display("FAIL drop_saturation: got drop=%0d narrow=%h, required %0d/F",
                     drop_cnt, s_drop_cnt, exp_drop);
        end
        n_checks++;
        if (s_pkt_cnt !== 4'((exp_pkt > 15) ? 15 : exp_pkt)) begin
            n_fails++;
            $display("FAIL narrow_pkt_cnt: got %0d, required %0d", s_pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int at, w0;
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), 200, -1, 1'b0, 1'b1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, wr_data, pkt_cnt, drop_cnt, busy, s_drop_cnt} !== '0) begin
            n_fails++;
            $display("FAIL async_reset: got en=%b data=%h pkt=%0d drop=%0d busy=%b narrow=%0d, required all zero",
                     wr_en, wr_data, pkt_cnt, drop_cnt, busy, s_drop_cnt);
        end
        exp_pkt  = 0;
        exp_drop = 0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        w0 = n_wr_seen;
        for (int i = 0; i < 60; i++) drive_byte(8'($urandom), 1'b0, 1'b0, 1'b0, at);
        idle(3);
        n_checks++;
        if (n_wr_seen !== w0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_no_sop: got writes=%0d busy=%b, required 0/0", n_wr_seen - w0, busy);
        end
        send_pkt(2'($urandom), 11'($urandom_range(0, V_LINES - 1)), PPP, -1, 1'b1, 1'b1);
        idle(4);
        n_checks++;
        if (n_wr_seen - w0 !== 600 || pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            n_fails++;
            $display("FAIL post_reset_packet: got writes=%0d pkt=%0d drop=%0d, required 600/1/0",
                     n_wr_seen - w0, pkt_cnt, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_header();
        test_fifo_full();
        test_short_long();
        test_sop_abort();
        test_saturation();
        test_reset_mid_packet();
        idle(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
